// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int   DATA_BITS = 8;
    localparam logic STOP_BIT  = 1'b1;

    // Clock cycles per bit period.
    function automatic int cpb(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. A push at full is accepted only when a pop
// frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign count   = cnt;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small byte FIFO, with sticky framing and
// overrun flags and a level interrupt while data is waiting.
//
// state | meaning
// IDLE  | line idle, waiting for rxs to fall
// START | half-bit wait, then confirm the start bit is still low
// DATA  | sample one data bit per bit period, LSB first
// STOP  | sample the stop bit, push or flag framing error
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     uart_rxd,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [7:0]               rx_data,
    output logic                     rx_empty,
    output logic                     rx_full,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic                     rx_ferr,
    output logic                     rx_ovr,
    output logic                     rx_irq
);

    localparam int CPB = cpb(CLK_HZ, BAUD);
    localparam int CW  = $clog2(CPB);
    // The IDLE detect and the synchroniser eat two cycles of the half-bit wait.
    localparam logic [CW-1:0] HALF_LOAD = CW'(CPB/2 - 2);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CPB - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    logic                  rx_meta;
    logic                  rxs;
    rx_state_e             state;
    rx_state_e             state_nxt;
    logic [CW-1:0]         baud_cnt;
    logic [CW-1:0]         baud_cnt_nxt;
    logic [2:0]            bit_idx;
    logic [2:0]            bit_idx_nxt;
    logic [DATA_BITS-1:0]  shift_reg;
    logic [DATA_BITS-1:0]  shift_reg_nxt;
    logic                  baud_tc;
    logic                  push_req;
    logic                  ferr_evt;
    logic                  ovr_evt;
    logic                  fifo_full;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_reg <= shift_reg_nxt;
        end
    end

    assign baud_tc = (baud_cnt == '0);

    always_comb begin
        state_nxt     = state;
        baud_cnt_nxt  = baud_cnt;
        bit_idx_nxt   = bit_idx;
        shift_reg_nxt = shift_reg;
        push_req      = 1'b0;
        ferr_evt      = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    baud_cnt_nxt = HALF_LOAD;
                    state_nxt    = START;
                end
            end
            START: begin
                if (!baud_tc) begin
                    baud_cnt_nxt = baud_cnt - CW'(1);
                end else if (rxs) begin
                    state_nxt = IDLE;
                end else begin
                    baud_cnt_nxt = BIT_LOAD;
                    bit_idx_nxt  = '0;
                    state_nxt    = DATA;
                end
            end
            DATA: begin
                if (!baud_tc) begin
                    baud_cnt_nxt = baud_cnt - CW'(1);
                end else begin
                    baud_cnt_nxt  = BIT_LOAD;
                    shift_reg_nxt = {rxs, shift_reg[DATA_BITS-1:1]};
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (!baud_tc) begin
                    baud_cnt_nxt = baud_cnt - CW'(1);
                end else begin
                    // Return without waiting out the stop bit so back-to-back frames align.
                    state_nxt = IDLE;
                    if (rxs == STOP_BIT) begin
                        push_req = 1'b1;
                    end else begin
                        ferr_evt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A full FIFO is never empty, so rd_en always frees a slot here.
    assign ovr_evt = push_req & fifo_full & ~rd_en;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            rx_ferr <= 1'b0;
            rx_ovr  <= 1'b0;
        end else begin
            if (ferr_evt) begin
                rx_ferr <= 1'b1;
            end else if (clr_err) begin
                rx_ferr <= 1'b0;
            end
            if (ovr_evt) begin
                rx_ovr <= 1'b1;
            end else if (clr_err) begin
                rx_ovr <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .push    (push_req),
        .pop     (rd_en),
        .din     (shift_reg),
        .dout    (rx_data),
        .empty   (rx_empty),
        .full    (fifo_full),
        .count   (rx_count)
    );

    assign rx_full = fifo_full;
    assign rx_irq  = ~rx_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at CPB=10, DEPTH=4.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int CPB   = 10;
    localparam int DEPTH = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_full;
    logic [2:0] rx_count;
    logic       rx_ferr;
    logic       rx_ovr;
    logic       rx_irq;

    int errors = 0;
    int checks = 0;
    logic [7:0] q[$];
    int cyc = 0;
    int fall_cyc = -1;
    logic prev_empty = 1'b1;

    uart_rx_fifo #(
        .CLK_HZ (1000),
        .BAUD   (100),
        .DEPTH  (DEPTH)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .uart_rxd (uart_rxd),
        .rd_en    (rd_en),
        .clr_err  (clr_err),
        .rx_data  (rx_data),
        .rx_empty (rx_empty),
        .rx_full  (rx_full),
        .rx_count (rx_count),
        .rx_ferr  (rx_ferr),
        .rx_ovr   (rx_ovr),
        .rx_irq   (rx_irq)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc = cyc + 1;

    always @(posedge sys_clk) begin
        #1;
        if (prev_empty === 1'b1 && rx_empty === 1'b0) fall_cyc = cyc;
        prev_empty = rx_empty;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        uart_rxd = b;
        repeat (CPB) tick();
    endtask

    // act: 0 none, 1 clr_err on the stop-sample edge, 2 rd_en on the stop-sample edge
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int act);
        drive_bit(1'b0);
        for (int b = 0; b < 8; b++) drive_bit(d[b]);
        uart_rxd = stop_ok;
        for (int i = 0; i < CPB; i++) begin
            if (!stop_ok && i == CPB/2) uart_rxd = 1'b1;
            if (i == CPB/2 + 1) begin
                if (act == 1) clr_err = 1'b1;
                if (act == 2) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL pop_at_push: scoreboard empty, rx_data=%h", rx_data);
                    end else begin
                        if (rx_data !== q[0]) begin
                            errors++;
                            $display("FAIL pop_at_push: got %h want %h", rx_data, q[0]);
                        end
                        void'(q.pop_front());
                    end
                    rd_en = 1'b1;
                end
                if (stop_ok && q.size() < DEPTH) q.push_back(d);
            end
            if (i == CPB/2 + 2) begin
                clr_err = 1'b0;
                rd_en   = 1'b0;
            end
            tick();
        end
    endtask

    task automatic read_check(input string name);
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, rx_empty=%b rx_data=%h", name, rx_empty, rx_data);
        end else begin
            if (rx_empty !== 1'b0 || rx_data !== q[0]) begin
                errors++;
                $display("FAIL %s: got empty=%b data=%h want empty=0 data=%h", name, rx_empty, rx_data, q[0]);
            end
            void'(q.pop_front());
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rx_count !== 3'(q.size())) begin
            errors++;
            $display("FAIL %s_count: got %0d want %0d", name, rx_count, q.size());
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b0;
        uart_rxd = 1'b1;
        repeat (3) tick();
        checks++;
        if ({rx_data, rx_count, rx_empty, rx_full, rx_ferr, rx_ovr, rx_irq} !== {8'h00, 3'd0, 5'b10000}) begin
            errors++;
            $display("FAIL reset_vals: got data=%h cnt=%0d e=%b f=%b fe=%b ov=%b irq=%b", rx_data, rx_count, rx_empty, rx_full, rx_ferr, rx_ovr, rx_irq);
        end
        sys_rst = 1'b1;
        tick();
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want IDLE", dut.state);
        end
    endtask

    task automatic test_single();
        int pin_cyc;
        pin_cyc = cyc;
        fall_cyc = -1;
        send_frame(8'h5A, 1'b1, 0);
        checks++;
        if (fall_cyc - pin_cyc != 97) begin
            errors++;
            $display("FAIL latency: got %0d want 97", fall_cyc - pin_cyc);
        end
        checks++;
        if (rx_data !== 8'h5A || rx_count !== 3'd1 || rx_irq !== 1'b1) begin
            errors++;
            $display("FAIL single: got data=%h cnt=%0d irq=%b want 5a 1 1", rx_data, rx_count, rx_irq);
        end
        read_check("single_read");
        checks++;
        if (rx_empty !== 1'b1 || rx_data !== 8'h00 || rx_irq !== 1'b0) begin
            errors++;
            $display("FAIL single_empty: got empty=%b data=%h irq=%b want 1 00 0", rx_empty, rx_data, rx_irq);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat [3];
        pat[0] = 8'h01; pat[1] = 8'h80; pat[2] = 8'hFF;
        for (int k = 0; k < 3; k++) send_frame(pat[k], 1'b1, 0);
        checks++;
        if (rx_ferr !== 1'b0 || rx_count !== 3'd3) begin
            errors++;
            $display("FAIL b2b: got ferr=%b cnt=%0d want 0 3", rx_ferr, rx_count);
        end
        for (int k = 0; k < 3; k++) read_check("b2b_read");
    endtask

    task automatic test_overrun();
        for (int k = 0; k < 5; k++) send_frame(8'h10 + 8'(k), 1'b1, 0);
        checks++;
        if (rx_count !== 3'd4 || rx_full !== 1'b1 || rx_ovr !== 1'b1) begin
            errors++;
            $display("FAIL overrun: got cnt=%0d full=%b ovr=%b want 4 1 1", rx_count, rx_full, rx_ovr);
        end
        for (int k = 0; k < 4; k++) read_check("ovr_read");
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if (rx_ovr !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear: got %b want 0", rx_ovr);
        end
        for (int k = 0; k < 4; k++) send_frame(8'h20 + 8'(k), 1'b1, 0);
        send_frame(8'h24, 1'b1, 2);
        checks++;
        if (rx_count !== 3'd4 || rx_ovr !== 1'b0) begin
            errors++;
            $display("FAIL push_pop_full: got cnt=%0d ovr=%b want 4 0", rx_count, rx_ovr);
        end
        for (int k = 0; k < 4; k++) read_check("ovr_read2");
    endtask

    task automatic test_frame_error();
        send_frame(8'h33, 1'b0, 0);
        checks++;
        if (rx_ferr !== 1'b1 || rx_empty !== 1'b1) begin
            errors++;
            $display("FAIL ferr: got ferr=%b empty=%b want 1 1", rx_ferr, rx_empty);
        end
        send_frame(8'h33, 1'b0, 1);
        checks++;
        if (rx_ferr !== 1'b1 || rx_empty !== 1'b1) begin
            errors++;
            $display("FAIL ferr_set_wins: got ferr=%b empty=%b want 1 1", rx_ferr, rx_empty);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if (rx_ferr !== 1'b0) begin
            errors++;
            $display("FAIL ferr_clear: got %b want 0", rx_ferr);
        end
    endtask

    task automatic test_glitch();
        uart_rxd = 1'b0;
        repeat (3) tick();
        uart_rxd = 1'b1;
        repeat (8) tick();
        checks++;
        if (dut.state !== IDLE || rx_empty !== 1'b1 || rx_ferr !== 1'b0) begin
            errors++;
            $display("FAIL glitch: got state=%0d empty=%b ferr=%b want IDLE 1 0", dut.state, rx_empty, rx_ferr);
        end
        repeat (2) tick();
        send_frame(8'hC3, 1'b1, 0);
        read_check("glitch_read");
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        send_frame(8'h11, 1'b1, 0);
        d = 8'hA5;
        drive_bit(1'b0);
        for (int b = 0; b < 4; b++) drive_bit(d[b]);
        uart_rxd = d[4];
        sys_rst = 1'b0;
        repeat (2) tick();
        q.delete();
        checks++;
        if ({rx_data, rx_count, rx_empty, rx_full, rx_ferr, rx_ovr, rx_irq} !== {8'h00, 3'd0, 5'b10000}) begin
            errors++;
            $display("FAIL midreset_vals: got data=%h cnt=%0d e=%b f=%b fe=%b ov=%b irq=%b", rx_data, rx_count, rx_empty, rx_full, rx_ferr, rx_ovr, rx_irq);
        end
        sys_rst = 1'b1;
        uart_rxd = 1'b1;
        repeat (2*CPB) tick();
        checks++;
        if (dut.state !== IDLE || rx_empty !== 1'b1 || rx_count !== 3'd0) begin
            errors++;
            $display("FAIL midreset_after: got state=%0d empty=%b cnt=%0d want IDLE 1 0", dut.state, rx_empty, rx_count);
        end
        send_frame(8'hA5, 1'b1, 0);
        read_check("midreset_read");
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 10; k++) begin
            send_frame(8'(k * 37 + 5), 1'b1, 0);
            read_check("wrap_read");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_error();
        test_glitch();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
